sevenseg_scan_driver: RTL
=========================

// Module: sevenseg_scan_driver
// PURPOSE
//  Parametrised time-multiplexed seven-segment scanner for the board top level (drives out7/en_out).
//  Displays NUM_DIGITS hex nibbles (PC, register or HI/LO values) with per-digit blanking.
//  Inter-digit dead time suppresses ghosting; a valid/ready shadow register gives tear-free, frame-aligned updates.
// PARAMETERS
//  NUM_DIGITS    8       digits scanned (1..16)
//  REFRESH_DIV   100000  clock cycles each digit is enabled (>=1)
//  DEAD_CYCLES   0       cycles with all enables off between digits (0 = no dead time)
//  SEG_ACT_LOW   1       1: out7 bits are active-low
//  EN_ACT_LOW    1       1: en_out bits are active-low
// PORTS
//  Clk          in   1             system clock, rising edge
//  Rst          in   1             asynchronous, active-high reset
//  data_in      in   4*NUM_DIGITS  nibble k -> digit k (digit 0 = rightmost, least significant)
//  blank_in     in   NUM_DIGITS    1 = digit k dark; captured together with data_in
//  data_valid   in   1             new frame offered
//  data_ready   out  1             shadow register empty; transfer on data_valid & data_ready
//  out7         out  7             {g,f,e,d,c,b,a} segments of the active digit
//  en_out       out  NUM_DIGITS    one-hot digit enable (polarity per EN_ACT_LOW)
//  frame_start  out  1             1-cycle pulse when digit 0 is enabled
// BEHAVIOUR
//  - Reset (async): digit index 0, prescaler 0, state S_ON, display and shadow regs 0, shadow empty.
//    Outputs: out7 and en_out all off (polarity applied), data_ready=1, frame_start=0.
//  - FSM S_ON: en_out enables digit idx for exactly REFRESH_DIV cycles. Then S_DEAD if DEAD_CYCLES>0, else advance.
//  - FSM S_DEAD: all enables off, out7 all off, for DEAD_CYCLES cycles; then advance.
//  - Advance: idx = (idx==NUM_DIGITS-1) ? 0 : idx+1. On wrap to 0 a frame boundary occurs.
//  - Outputs are registered and change on the same edge as the state/index change; no combinational glitches.
//  - First frame after reset: the first edge after Rst deasserts enables digit 0 and pulses frame_start.
//  - Handshake: data_ready = !shadow_full (registered). On valid&ready, capture data_in/blank_in and set shadow_full.
//    data_valid while data_ready=0 is ignored; the source holds or retries.
//  - Frame boundary with shadow_full: display <= shadow and shadow_full cleared in the same edge.
//    The new frame shows from digit 0. data_ready rises on the next cycle.
//  - Same-cycle valid&ready and frame boundary: capture into the shadow only. It displays at the next boundary.
//  - Decode: nibble 0-F -> standard hex glyphs (A,b,C,d,E,F). A blanked digit drives all segments off while still enabled.
//  - Prescaler and dead counters are $clog2-sized, count 0..N-1 and wrap without overflow.
//  - Rst mid-scan aborts immediately and discards any pending shadow frame.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined:
//    - Starting at digit NUM_DIGITS-1 and moving down, contiguous zero nibbles are blanked.
//    - Digit 0 is never zero-suppressed.
//    - The mask is computed at display-register load and ORed with blank_in.
//  Not defined: only blank_in blanks a digit; zeros display as "0".
// STRUCTURE
//  - sevenseg_pkg: 16-entry hex glyph constants (active-high), state encoding S_ON/S_DEAD, polarity helper function.
//  - Sub-module hex_to_7seg: combinational nibble->segment decode, instantiated once on the muxed nibble.
//  - Top: prescaler, dead counter, idx counter, FSM, shadow/display registers, output polarity registers.
// TESTING (NUM_DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=1, both ACT_LOW=1, 200 ns clock)
//  1. Reset held mid-cycle -> out7=7'h7F, en_out=4'hF, data_ready=1 asynchronously.
//     After release: en_out=4'hE for 4 cycles, then 4'hF for 1 cycle, then 4'hD.
//  2. data_in=16'h12AF, valid 1 cycle -> data_ready=0 until the next boundary.
//     Next frame digits 0..3 show F,A,2,1 (out7=7'h0E,7'h08,7'h24,7'h79).
//  3. Valid held for 3 frames with changing data -> only the values present when ready=1 are captured.
//     No frame mixes old and new nibbles.
//  4. blank_in=4'b0101 -> digits 0 and 2 show out7=7'h7F while their en_out bit is still low (enabled).
//  5. With LEADING_ZERO_BLANK_EN and data_in=16'h0000 -> only digit 0 lit as "0" (7'h40).
//     data_in=16'h0050 -> digits 3 and 2 blank, digit 1 "5", digit 0 "0".
//  6. Valid coincident with a frame boundary while the shadow is empty -> capture only.
//     Display changes one full frame later; frame_start pulses once per 20 cycles.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: hex glyph table, scan states and output polarity helper for sevenseg_scan_driver
package sevenseg_pkg;

    typedef enum logic {S_ON, S_DEAD} scan_state_t;

    // Active-high {g,f,e,d,c,b,a} patterns for 0-9, A, b, C, d, E, F
    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] seg_pol(input logic [6:0] seg, input logic act_low);
        return act_low ? ~seg : seg;
    endfunction

endpackage

// File: rtl/sevenseg_scan_driver_hex_to_7seg.sv
// hex_to_7seg: combinational nibble to active-high seven-segment glyph decode
module hex_to_7seg
    import sevenseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_GLYPH[nibble];

endmodule

// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver: multiplexed hex display scanner with dead time and frame-aligned shadow updates
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits (never digit 0) when a frame is loaded.
module sevenseg_scan_driver
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYCLES = 0,
    parameter int SEG_ACT_LOW = 1,
    parameter int EN_ACT_LOW  = 1
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    data_valid,
    output logic                    data_ready,
    output logic [6:0]              out7,
    output logic [NUM_DIGITS-1:0]   en_out,
    output logic                    frame_start
);

    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    localparam int DW = DEAD_CYCLES > 1 ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYCLES > 0 ? DEAD_CYCLES - 1 : 0);
    localparam logic [NUM_DIGITS-1:0] EN_OFF = {NUM_DIGITS{EN_ACT_LOW != 0}};

    scan_state_t state, nxt_state;
    logic [IW-1:0] idx, nxt_idx;
    logic [PW-1:0] pre, nxt_pre;
    logic [DW-1:0] dead, nxt_dead;
    logic pre_done, dead_done, adv, boundary, take, lit;
    logic shadow_full;
    logic [NUM_DIGITS-1:0][3:0] shadow_data, disp_data;
    logic [NUM_DIGITS-1:0] shadow_blank, disp_blank, lz_mask, onehot;
    logic [6:0] glyph;

    always_comb begin
        pre_done  = pre == PRE_LAST;
        dead_done = dead == DEAD_LAST;
        adv       = state == S_ON ? pre_done && DEAD_CYCLES == 0 : dead_done;
        boundary  = adv && idx == IDX_LAST;
        nxt_state = state == S_ON ? (pre_done && DEAD_CYCLES != 0 ? S_DEAD : S_ON) : (dead_done ? S_ON : S_DEAD);
        nxt_pre   = state == S_ON && !pre_done ? pre + 1'b1 : '0;
        nxt_dead  = state == S_DEAD && !dead_done ? dead + 1'b1 : '0;
        nxt_idx   = !adv ? idx : boundary ? '0 : idx + 1'b1;
        take      = data_valid && !shadow_full;
        lit       = state == S_ON && !disp_blank[idx];
        onehot    = state == S_ON ? NUM_DIGITS'(1) << idx : '0;
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic lz_run;
    always_comb begin
        lz_mask = '0;
        lz_run  = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            lz_run     = lz_run && shadow_data[k] == 4'h0;
            lz_mask[k] = lz_run;
        end
    end
`else
    assign lz_mask = '0;
`endif

    assign data_ready = !shadow_full;

    hex_to_7seg u_dec (
        .nibble (disp_data[idx]),
        .seg    (glyph)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= S_ON;
            idx   <= '0;
            pre   <= '0;
            dead  <= '0;
        end else begin
            state <= nxt_state;
            idx   <= nxt_idx;
            pre   <= nxt_pre;
            dead  <= nxt_dead;
        end
    end

    // A pending frame is only promoted at the wrap to digit 0, so no frame mixes old and new nibbles
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            shadow_full  <= 1'b0;
            shadow_data  <= '0;
            shadow_blank <= '0;
            disp_data    <= '0;
            disp_blank   <= '0;
        end else if (boundary && shadow_full) begin
            disp_data   <= shadow_data;
            disp_blank  <= shadow_blank | lz_mask;
            shadow_full <= 1'b0;
        end else if (take) begin
            shadow_data  <= data_in;
            shadow_blank <= blank_in;
            shadow_full  <= 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            out7        <= seg_pol(7'h00, SEG_ACT_LOW != 0);
            en_out      <= EN_OFF;
            frame_start <= 1'b0;
        end else begin
            out7        <= seg_pol(lit ? glyph : 7'h00, SEG_ACT_LOW != 0);
            en_out      <= onehot ^ EN_OFF;
            frame_start <= state == S_ON && idx == '0 && pre == '0;
        end
    end

endmodule
